// File: rtl/adc_ram_reader_if.sv
// adc_ram_reader_if: bundles the signals between the capture RAM, the reader
// and the readout stream.
//   wr_addr/wr_en    tap of the capture block's RAM write port
//   rd_addr/rd_en    RAM port-B read request (driven by the reader)
//   rd_data          RAM port-B read data
//   out_data/out_valid/out_ready  valid/ready readout stream
// The slave modport is the reader's view; master is the environment's view.
interface adc_ram_reader_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  wr_addr, wr_en, rd_data, out_ready,
        output rd_addr, rd_en, out_data, out_valid
    );

    modport master (
        output wr_addr, wr_en, rd_data, out_ready,
        input  rd_addr, rd_en, out_data, out_valid
    );
endinterface

// File: rtl/adc_ram_reader.sv
// adc_ram_reader: follows the capture RAM write port, reads the written words
// back through port B in write order and streams them out through a 4-entry
// FIFO, so output back-pressure never stalls capture.
//   clk, reset     clock and asynchronous active-high reset
//   clear_i        synchronous flush (tracking, FIFO, in-flight reads, flags)
//   enable_i       permits issuing RAM reads
//   bus            RAM tap, RAM port B and output stream (slave modport)
//   level_o        words written but not yet read from the RAM
//   overflow_o     sticky: the writer lapped the reader
//   seq_err_o      sticky: a write was not at the expected next address
module adc_ram_reader #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear_i,
    input  logic            enable_i,
    adc_ram_reader_if.slave bus,
    output logic [ADDR_W:0] level_o,
    output logic            overflow_o,
    output logic            seq_err_o
);
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned PTR_W      = 2;
    localparam int unsigned CNT_W      = 3;
    localparam int unsigned PEND_W     = ADDR_W + 1;
    localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(1) << ADDR_W;

    typedef enum logic {
        ST_UNSYNC,
        ST_SYNC
    } state_e;

    state_e                              state_q, state_d;
    logic [ADDR_W-1:0]                   rptr_q, rptr_d;
    logic [ADDR_W-1:0]                   wexp_q, wexp_d;
    logic [PEND_W-1:0]                   pend_q, pend_d;
    logic [RD_LATENCY-1:0]               infl_q, infl_d;
    logic [FIFO_DEPTH-1:0][DATA_W-1:0]   fifo_q, fifo_d;
    logic [PTR_W-1:0]                    wptr_q, wptr_d;
    logic [PTR_W-1:0]                    hptr_q, hptr_d;
    logic [CNT_W-1:0]                    count_q, count_d;
    logic                                ovf_q, ovf_d;
    logic                                seq_q, seq_d;

    logic [CNT_W-1:0] infl_cnt;
    logic             issue_c;
    logic             ret_c;
    logic             valid_c;
    logic             pop_c;

    // Reads still travelling through the RAM pipeline.
    always_comb begin
        infl_cnt = '0;
        for (int i = 0; i < int'(RD_LATENCY); i++) begin
            infl_cnt = infl_cnt + CNT_W'(infl_q[i]);
        end
    end

    // Credit rule: FIFO entries plus in-flight reads never exceed the FIFO depth.
    assign issue_c = enable_i && (state_q == ST_SYNC) && (pend_q != '0)
                     && ((count_q + infl_cnt) < CNT_W'(FIFO_DEPTH));
    assign ret_c   = infl_q[RD_LATENCY-1];
    assign valid_c = (count_q != '0);
    assign pop_c   = valid_c && bus.out_ready;

    assign bus.rd_en     = issue_c;
    assign bus.rd_addr   = rptr_q;
    assign bus.out_valid = valid_c;
    assign bus.out_data  = valid_c ? fifo_q[hptr_q] : '0;
    assign level_o       = pend_q;
    assign overflow_o    = ovf_q;
    assign seq_err_o     = seq_q;

    // Next-state: write tracking, read issue, FIFO push/pop; clear overrides all.
    always_comb begin
        state_d = state_q;
        rptr_d  = rptr_q;
        wexp_d  = wexp_q;
        pend_d  = pend_q;
        infl_d  = RD_LATENCY'(infl_q << 1) | RD_LATENCY'(issue_c);
        fifo_d  = fifo_q;
        wptr_d  = wptr_q;
        hptr_d  = hptr_q;
        count_d = count_q + CNT_W'(ret_c) - CNT_W'(pop_c);
        ovf_d   = ovf_q;
        seq_d   = seq_q;

        if (ret_c) begin
            fifo_d[wptr_q] = bus.rd_data;
            wptr_d         = wptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            hptr_d = hptr_q + PTR_W'(1);
        end

        if (issue_c) begin
            rptr_d = rptr_q + ADDR_W'(1);
        end

        if (bus.wr_en) begin
            if (state_q == ST_UNSYNC) begin
                // First observed write defines where the ring starts.
                state_d = ST_SYNC;
                rptr_d  = bus.wr_addr;
                wexp_d  = bus.wr_addr + ADDR_W'(1);
                pend_d  = PEND_W'(1);
            end else begin
                wexp_d = bus.wr_addr + ADDR_W'(1);
                if (bus.wr_addr != wexp_q) begin
                    seq_d = 1'b1;
                end
                if ((pend_q == PEND_FULL) && !issue_c) begin
                    // Ring full: the oldest unread word is overwritten, skip it.
                    ovf_d  = 1'b1;
                    rptr_d = rptr_q + ADDR_W'(1);
                end else begin
                    pend_d = pend_q + PEND_W'(1) - PEND_W'(issue_c);
                end
            end
        end else begin
            pend_d = pend_q - PEND_W'(issue_c);
        end

        if (clear_i) begin
            state_d = ST_UNSYNC;
            rptr_d  = rptr_q;
            wexp_d  = wexp_q;
            pend_d  = '0;
            infl_d  = '0;
            fifo_d  = fifo_q;
            wptr_d  = '0;
            hptr_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            seq_d   = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_UNSYNC;
            rptr_q  <= '0;
            wexp_q  <= '0;
            pend_q  <= '0;
            infl_q  <= '0;
            fifo_q  <= '0;
            wptr_q  <= '0;
            hptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            seq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rptr_q  <= rptr_d;
            wexp_q  <= wexp_d;
            pend_q  <= pend_d;
            infl_q  <= infl_d;
            fifo_q  <= fifo_d;
            wptr_q  <= wptr_d;
            hptr_q  <= hptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            seq_q   <= seq_d;
        end
    end
endmodule

// File: tb/tb_adc_ram_reader.sv
// Testbench for adc_ram_reader: behavioural RAM with a two-cycle read port,
// a scoreboard model checked every cycle, directed scenarios and random traffic.
module tb_adc_ram_reader;
    localparam int unsigned AW   = 12;
    localparam int unsigned DW   = 32;
    localparam int unsigned LAT  = 2;
    localparam int          RING = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          clear;
    logic          enable;
    logic [AW:0]   level;
    logic          overflow;
    logic          seq_err;
    logic [DW-1:0] wdata;
    logic [DW-1:0] mem [RING];
    logic [DW-1:0] rd_s1;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Scoreboard model state
    bit            m_synced;
    int            m_pending;
    int            m_rptr;
    int            m_wexp;
    bit            m_ovf;
    bit            m_seq;
    int            exp_q[$];
    int            rd_log[$];
    int            rd_cnt  = 0;
    int            pop_cnt = 0;
    bit            prev_hold;
    logic [DW-1:0] prev_data;

    adc_ram_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    adc_ram_reader #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (clear),
        .enable_i  (enable),
        .bus       (bus),
        .level_o   (level),
        .overflow_o(overflow),
        .seq_err_o (seq_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Dual-port RAM: port A written by capture, port B with two-cycle read latency
    always @(posedge clk) begin
        if (bus.wr_en) mem[bus.wr_addr] <= wdata;
        if (bus.rd_en) rd_s1 <= mem[bus.rd_addr];
        bus.rd_data <= rd_s1;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int log_at(input int i);
        return (i < rd_log.size()) ? rd_log[i] : -1;
    endfunction

    // Per-cycle compare of DUT against the model, then advance the model
    always @(negedge clk) begin
        if (reset) begin
            m_synced = 0; m_pending = 0; m_rptr = 0; m_wexp = 0;
            m_ovf = 0; m_seq = 0; exp_q.delete(); prev_hold = 0;
        end
        chk("level", level, m_pending);
        chk("overflow", overflow, m_ovf);
        chk("seq_err", seq_err, m_seq);
        chk("rd_addr", bus.rd_addr, m_rptr);
        if (reset) begin
            chk("rst_rd_en", bus.rd_en, 0);
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_out_data", bus.out_data, 0);
        end else begin
            if (prev_hold) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_data", bus.out_data, prev_data);
            end
            if (bus.out_valid) begin
                chk("valid_has_word", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("out_data", bus.out_data, mem[exp_q[0]]);
            end
            if (bus.rd_en)
                chk("rd_en_legal", enable && m_synced && m_pending > 0 && exp_q.size() < 4, 1);
            if (enable && m_synced && m_pending > 0 && exp_q.size() == 0)
                chk("rd_en_live", bus.rd_en, 1);

            if (clear) begin
                m_synced = 0; m_pending = 0; m_ovf = 0; m_seq = 0;
                exp_q.delete(); prev_hold = 0;
            end else begin
                if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    pop_cnt++;
                end
                prev_hold = bus.out_valid && !bus.out_ready;
                prev_data = bus.out_data;
                if (bus.rd_en) begin
                    exp_q.push_back(int'(bus.rd_addr));
                    rd_log.push_back(int'(bus.rd_addr));
                    rd_cnt++;
                    m_rptr = (m_rptr + 1) % RING;
                end
                if (bus.wr_en) begin
                    if (!m_synced) begin
                        m_synced  = 1;
                        m_rptr    = int'(bus.wr_addr);
                        m_wexp    = (int'(bus.wr_addr) + 1) % RING;
                        m_pending = 1;
                    end else begin
                        if (int'(bus.wr_addr) != m_wexp) m_seq = 1;
                        m_wexp = (int'(bus.wr_addr) + 1) % RING;
                        if (m_pending == RING && !bus.rd_en) begin
                            m_ovf  = 1;
                            m_rptr = (m_rptr + 1) % RING;
                        end else begin
                            m_pending = m_pending + 1 - int'(bus.rd_en);
                        end
                    end
                end else if (bus.rd_en) begin
                    m_pending--;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int a);
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(a);
        wdata       = $urandom;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic drain(input string name, input int max);
        int n = 0;
        while (!(level == 0 && !bus.out_valid && exp_q.size() == 0) && n < max) begin
            tick();
            n++;
        end
        chk({name, "_drained"}, n < max, 1);
    endtask

    initial begin
        int t0, trd, tv, base, p0, nv, a, nwr;
        int wrap_exp[4];
        wrap_exp = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};

        reset = 1'b1; clear = 1'b0; enable = 1'b0; wdata = '0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rd_en", bus.rd_en, 0);
        chk("reset_rd_addr", bus.rd_addr, 0);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_out_data", bus.out_data, 0);
        chk("reset_level", level, 0);
        reset = 1'b0; enable = 1'b1; bus.out_ready = 1'b1;
        tick();

        // Basic order and latency
        base = rd_cnt; p0 = pop_cnt; trd = -1; tv = -1; t0 = cyc;
        fork
            for (int i = 0; i < 8; i++) write_word(16'h0010 + i);
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (bus.rd_en && trd < 0) trd = cyc - t0;
                if (bus.out_valid && tv < 0) tv = cyc - t0;
            end
        join
        tick();
        chk("basic_rd_en_cycle", trd, 1);
        chk("basic_valid_cycle", tv, 4);
        drain("basic", 50);
        chk("basic_pops", pop_cnt - p0, 8);
        chk("basic_first_addr", log_at(base), 12'h010);
        chk("basic_last_addr", log_at(base + 7), 12'h017);
        chk("basic_level", level, 0);
        chk("basic_seq_err", seq_err, 0);

        // Wrap-around
        do_clear();
        base = rd_cnt;
        for (int i = 0; i < 4; i++) write_word(wrap_exp[i]);
        drain("wrap", 50);
        for (int i = 0; i < 4; i++) chk("wrap_rd_addr", log_at(base + i), wrap_exp[i]);
        chk("wrap_seq_err", seq_err, 0);

        // Back-pressure
        do_clear();
        bus.out_ready = 1'b0;
        base = rd_cnt; p0 = pop_cnt;
        for (int i = 0; i < 20; i++) write_word(12'h300 + i);
        repeat (10) tick();
        chk("bp_rd_pulses", rd_cnt - base, 4);
        chk("bp_level", level, 16);
        chk("bp_valid", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        drain("bp", 200);
        chk("bp_pops", pop_cnt - p0, 20);
        chk("bp_reads", rd_cnt - base, 20);

        // Overflow
        do_clear();
        enable = 1'b0;
        for (int i = 0; i <= RING; i++) write_word(i % RING);
        chk("ovf_flag", overflow, 1);
        chk("ovf_level", level, RING);
        chk("ovf_rptr", bus.rd_addr, 1);
        chk("ovf_seq_err", seq_err, 0);
        base = rd_cnt;
        enable = 1'b1;
        drain("ovf", 6000);
        chk("ovf_first_addr", log_at(base), 1);
        chk("ovf_reads", rd_cnt - base, RING);

        // Sequence error
        do_clear();
        p0 = pop_cnt;
        write_word(12'h100);
        write_word(12'h101);
        bus.wr_en = 1'b1; bus.wr_addr = 12'h105; wdata = $urandom;
        @(negedge clk);
        chk("seq_not_early", seq_err, 0);
        tick();
        bus.wr_en = 1'b0;
        chk("seq_flag", seq_err, 1);
        drain("seq", 50);
        chk("seq_pops", pop_cnt - p0, 3);

        // Clear one cycle after a read is issued
        do_clear();
        write_word(12'h200);
        chk("clr_rd_en", bus.rd_en, 1);
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        nv = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.out_valid) nv++;
        end
        tick();
        chk("clr_no_valid", nv, 0);
        chk("clr_level", level, 0);
        chk("clr_flags", {overflow, seq_err}, 0);

        // Random traffic
        for (int r = 0; r < 4; r++) begin
            do_clear();
            a = int'($urandom_range(RING - 1));
            nwr = 0;
            for (int c = 0; c < 400; c++) begin
                enable        = ($urandom_range(7) != 0);
                bus.out_ready = $urandom_range(1);
                if (nwr < 200 && $urandom_range(2) != 0) begin
                    if ($urandom_range(49) == 0) a = a + 1 + int'($urandom_range(2));
                    bus.wr_en   = 1'b1;
                    bus.wr_addr = AW'(a);
                    wdata       = $urandom;
                    a++;
                    nwr++;
                end else begin
                    bus.wr_en = 1'b0;
                end
                tick();
            end
            bus.wr_en = 1'b0; enable = 1'b1; bus.out_ready = 1'b1;
            drain("rand", 400);
        end

        // Asynchronous reset with data held in the FIFO and a flag set
        do_clear();
        bus.out_ready = 1'b0;
        write_word(12'h400);
        write_word(12'h402);
        repeat (5) tick();
        chk("pre_rst_valid", bus.out_valid, 1);
        chk("pre_rst_seq", seq_err, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_rd_en", bus.rd_en, 0);
        chk("arst_rd_addr", bus.rd_addr, 0);
        chk("arst_valid", bus.out_valid, 0);
        chk("arst_data", bus.out_data, 0);
        chk("arst_level", level, 0);
        chk("arst_flags", {overflow, seq_err}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) tick();
        chk("post_rst_valid", bus.out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
